video_timing_tx: RTL and testbench
==================================

VIDEO_TIMING_TX -- requirements
Module: video_timing_tx

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 110 / 40 / 220, horizontal front porch, sync and back porch in pixels; H_TOTAL = sum of the four horizontal parameters, 1650 by default.
REQ-003 SHALL have parameter V_ACT, default 720, active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 5 / 5 / 20, vertical porches and sync in lines; V_TOTAL = sum of the four vertical parameters, 750 by default.
REQ-005 SHALL have ports, clock and reset first:
- pixclk_in  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- clr_err  in  1  clears the sticky underflow flag.
- pix_valid_i  in  1  upstream pixel available.
- pix_data_i  in  24  {r,g,b} upstream pixel.
- pix_ready_o  out  1  pixel consumed this cycle.
- vs_out  out  1  vertical sync, active-high.
- hs_out  out  1  horizontal sync, active-high.
- de_out  out  1  data enable.
- data_out  out  24  {r,g,b} output pixel.
- sof_o  out  1  start-of-frame pulse.
- underflow_o  out  1  sticky underflow flag.
- run_o  out  1  generator running.

Function
REQ-006 SHALL keep an h counter (0..H_TOTAL-1) and a v counter (0..V_TOTAL-1), both 12 bits wide; v increments when h wraps from H_TOTAL-1 to 0, and v wraps from V_TOTAL-1 to 0.
REQ-007 SHALL treat the counter position as active when h<H_ACT and v<V_ACT.
REQ-008 SHALL drive pix_ready_o combinationally, equal to (state==RUN and active); a pixel transfers when pix_ready_o and pix_valid_i are both high.
REQ-009 SHALL register all video outputs with 1-cycle latency from the counter position.
REQ-010 SHALL set de_out to the registered active flag.
REQ-011 SHALL set hs_out high when H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC.
REQ-012 SHALL set vs_out high when V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC, for whole lines.
REQ-013 SHALL set data_out to pix_data_i on a transfer, and to 24'h000000 in every other cycle, including blanking and underflow.
REQ-014 SHALL set underflow_o, registered, when pix_ready_o is high and pix_valid_i is low; it SHALL hold until clr_err is high; a new underflow in the same cycle as clr_err wins (flag stays set).
REQ-015 SHALL pulse sof_o for exactly one cycle, aligned with the de_out cycle for position h=0, v=0.
REQ-016 SHALL implement a two-state FSM:
- IDLE: counters held at 0; pix_ready_o, de_out, hs_out, vs_out, sof_o are 0; run_o is 0.
- IDLE->RUN: when en is high; the next cycle has h=0, v=0.
- RUN: counters advance every cycle; run_o is 1.
- RUN->IDLE: only at h=H_TOTAL-1, v=V_TOTAL-1 with en low; frames are never truncated.
REQ-017 SHALL, when en is low at the frame end, finish that frame and return to IDLE; when en is high at the frame end, continue seamlessly with the next frame at (0,0).
REQ-018 SHALL NOT gate timing on pix_valid_i; timing never stalls.
REQ-019 SHALL ignore pix_valid_i outside active positions; no transfer occurs.

Reset
REQ-020 SHALL, on rst_n low, asynchronously force:
- state = IDLE, h = 0, v = 0;
- vs_out = hs_out = de_out = sof_o = 0;
- data_out = 0, underflow_o = 0, run_o = 0.
REQ-021 SHALL, when reset is asserted mid-frame, abort the frame immediately; after release, resume per REQ-016.
REQ-022 SHALL keep pix_ready_o low throughout reset.

Structure
REQ-023 SHALL place the following in the shared video package:
- default 1280x720 timing constants;
- the H_TOTAL/V_TOTAL derivation;
- the FSM state encoding;
- the 24-bit pixel width.
REQ-024 SHALL use one sub-module, video_timing_cnt, holding the h/v counters and the active/hs/vs decode; the top level owns the FSM, handshake, data path and flags.

Verification
All scenarios use H_ACT=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14) and V_ACT=4, V_FP=V_SYNC=V_BP=1 (V_TOTAL=7).
REQ-025 SHALL cover: reset, en=1, pix_valid_i held high with incrementing data -> first de_out 2 cycles after en is sampled; 8 de_out cycles per line; hs_out high for cycles 10-11 of each line; vs_out high for the whole of line 5; sof_o exactly once per 98-cycle frame.
REQ-026 SHALL cover: pix_valid_i=0 at line 1 pixel 3 -> data_out=0 with de_out=1 in that cycle; underflow_o=1 one cycle later; underflow_o stays 1 until clr_err pulses, then 0.
REQ-027 SHALL cover: en dropped at line 2 of frame 0 -> frame 0 completes all 98 cycles; then run_o=0 and pix_ready_o stays 0.
REQ-028 SHALL cover: rst_n low at h=5, v=2 -> all outputs 0 asynchronously, before the next clock edge; after release with en=1 -> a fresh frame starts from h=0, v=0.
REQ-029 SHALL cover: clr_err and a new underflow in the same cycle -> underflow_o remains 1.
REQ-030 SHALL cover: en held high for 3 frames -> sof_o period exactly 98 cycles, with no gap between frames.

Source files
------------

// File: rtl/video_timing_tx_pkg.sv
// Shared video timing definitions: default 1280x720 timing, totals, FSM encoding, pixel width.
package video_timing_tx_pkg;

  localparam int unsigned PixW = 24;
  localparam int unsigned CntW = 12;

  localparam int unsigned DefHAct  = 1280;
  localparam int unsigned DefHFp   = 110;
  localparam int unsigned DefHSync = 40;
  localparam int unsigned DefHBp   = 220;

  localparam int unsigned DefVAct  = 720;
  localparam int unsigned DefVFp   = 5;
  localparam int unsigned DefVSync = 5;
  localparam int unsigned DefVBp   = 20;

  function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned DefHTotal = calc_total(DefHAct, DefHFp, DefHSync, DefHBp);
  localparam int unsigned DefVTotal = calc_total(DefVAct, DefVFp, DefVSync, DefVBp);

  typedef enum logic {StIdle, StRun} state_e;

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical position counters with active, hsync and vsync decode.
module video_timing_cnt
  import video_timing_tx_pkg::*;
#(
  parameter int unsigned H_ACT  = DefHAct,
  parameter int unsigned H_FP   = DefHFp,
  parameter int unsigned H_SYNC = DefHSync,
  parameter int unsigned H_BP   = DefHBp,
  parameter int unsigned V_ACT  = DefVAct,
  parameter int unsigned V_FP   = DefVFp,
  parameter int unsigned V_SYNC = DefVSync,
  parameter int unsigned V_BP   = DefVBp
) (
  input  logic            pixclk_in,
  input  logic            rst_n,
  input  logic            run,
  output logic [CntW-1:0] h,
  output logic [CntW-1:0] v,
  output logic            active,
  output logic            hs,
  output logic            vs,
  output logic            frame_end
);

  localparam logic [CntW-1:0] HAct    = CntW'(H_ACT);
  localparam logic [CntW-1:0] HsStart = CntW'(H_ACT + H_FP);
  localparam logic [CntW-1:0] HsEnd   = CntW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CntW-1:0] HLast   = CntW'(calc_total(H_ACT, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CntW-1:0] VAct    = CntW'(V_ACT);
  localparam logic [CntW-1:0] VsStart = CntW'(V_ACT + V_FP);
  localparam logic [CntW-1:0] VsEnd   = CntW'(V_ACT + V_FP + V_SYNC);
  localparam logic [CntW-1:0] VLast   = CntW'(calc_total(V_ACT, V_FP, V_SYNC, V_BP) - 1);

  logic [CntW-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run) begin
      // Idle parks the counters at the frame origin.
      h_d = '0;
      v_d = '0;
    end else if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + CntW'(1);
    end else begin
      h_d = h_q + CntW'(1);
    end
  end

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign active    = (h_q < HAct) && (v_q < VAct);
  assign hs        = (h_q >= HsStart) && (h_q < HsEnd);
  assign vs        = (v_q >= VsStart) && (v_q < VsEnd);
  assign frame_end = (h_q == HLast) && (v_q == VLast);

endmodule

// File: rtl/video_timing_tx.sv
// Video timing transmitter: frame FSM, pixel handshake, registered video outputs and error flag.
module video_timing_tx
  import video_timing_tx_pkg::*;
#(
  parameter int unsigned H_ACT  = DefHAct,
  parameter int unsigned H_FP   = DefHFp,
  parameter int unsigned H_SYNC = DefHSync,
  parameter int unsigned H_BP   = DefHBp,
  parameter int unsigned V_ACT  = DefVAct,
  parameter int unsigned V_FP   = DefVFp,
  parameter int unsigned V_SYNC = DefVSync,
  parameter int unsigned V_BP   = DefVBp
) (
  input  logic            pixclk_in,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr_err,
  input  logic            pix_valid_i,
  input  logic [PixW-1:0] pix_data_i,
  output logic            pix_ready_o,
  output logic            vs_out,
  output logic            hs_out,
  output logic            de_out,
  output logic [PixW-1:0] data_out,
  output logic            sof_o,
  output logic            underflow_o,
  output logic            run_o
);

  state_e          state_q;
  logic            running;
  logic [CntW-1:0] h, v;
  logic            active, hs, vs, frame_end;
  logic            xfer, starve;

  assign running = (state_q == StRun);

  video_timing_cnt #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_cnt (
    .pixclk_in(pixclk_in),
    .rst_n    (rst_n),
    .run      (running),
    .h        (h),
    .v        (v),
    .active   (active),
    .hs       (hs),
    .vs       (vs),
    .frame_end(frame_end)
  );

  assign pix_ready_o = running && active;
  assign xfer        = pix_ready_o && pix_valid_i;
  assign starve      = pix_ready_o && !pix_valid_i;
  assign run_o       = running;

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      de_out      <= 1'b0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      sof_o       <= 1'b0;
      data_out    <= '0;
      underflow_o <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        if (en) state_q <= StRun;
      end else begin
        // Leave only at the last pixel of a frame so frames are never cut short.
        if (frame_end && !en) state_q <= StIdle;
      end
      de_out   <= pix_ready_o;
      hs_out   <= running && hs;
      vs_out   <= running && vs;
      sof_o    <= running && (h == '0) && (v == '0);
      data_out <= xfer ? pix_data_i : '0;
      // A fresh underflow outranks a simultaneous clear.
      if (starve) begin
        underflow_o <= 1'b1;
      end else if (clr_err) begin
        underflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_tx.sv
// Directed bench for video_timing_tx on a 14x7 timing grid (98 cycles per frame).
module tb_video_timing_tx;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        pixclk_in = 1'b0;
  logic        rst_n, en, clr_err, pix_valid_i;
  logic [23:0] pix_data_i;
  logic        pix_ready_o, vs_out, hs_out, de_out, sof_o, underflow_o, run_o;
  logic [23:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pixclk_in = ~pixclk_in;

  video_timing_tx #(
    .H_ACT (8),
    .H_FP  (2),
    .H_SYNC(2),
    .H_BP  (2),
    .V_ACT (4),
    .V_FP  (1),
    .V_SYNC(1),
    .V_BP  (1)
  ) dut (
    .pixclk_in  (pixclk_in),
    .rst_n      (rst_n),
    .en         (en),
    .clr_err    (clr_err),
    .pix_valid_i(pix_valid_i),
    .pix_data_i (pix_data_i),
    .pix_ready_o(pix_ready_o),
    .vs_out     (vs_out),
    .hs_out     (hs_out),
    .de_out     (de_out),
    .data_out   (data_out),
    .sof_o      (sof_o),
    .underflow_o(underflow_o),
    .run_o      (run_o)
  );

  task automatic check_eq(input string tag, input int c, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d, t=%0t): got %h expected %h", tag, c, $time, got, exp);
    end
  endtask

  function automatic logic [23:0] dat(input int c);
    return 24'hA50000 + 24'(c);
  endfunction

  function automatic bit valid_at(input int c, input bit inject);
    return !(inject && (c == 17 || c == FT + 16 || c == FT + 17));
  endfunction

  function automatic bit clr_at(input int c, input bit inject);
    return inject && (c == 40 || c == FT + 17 || c == FT + 30);
  endfunction

  function automatic bit ready_at(input int c, input int stop_at);
    return (c < stop_at) && ((c % HT) < 8) && (((c / HT) % VT) < 4);
  endfunction

  // Outputs registered from frame cycle c.
  task automatic chk_out(input int c, input int stop_at, input bit inject);
    bit run, rdy, uf;
    int h, v;
    run = c < stop_at;
    h   = c % HT;
    v   = (c / HT) % VT;
    rdy = ready_at(c, stop_at);
    uf  = inject && ((c >= 17 && c < 40) || (c >= FT + 16 && c < FT + 30));
    check_eq("de_out", c, 32'(de_out), 32'(rdy));
    check_eq("data_out", c, 32'(data_out), (rdy && valid_at(c, inject)) ? 32'(dat(c)) : 32'd0);
    check_eq("hs_out", c, 32'(hs_out), 32'(run && (h == 10 || h == 11)));
    check_eq("vs_out", c, 32'(vs_out), 32'(run && v == 5));
    check_eq("sof_o", c, 32'(sof_o), 32'(run && h == 0 && v == 0));
    check_eq("underflow_o", c, 32'(underflow_o), 32'(uf));
  endtask

  // Starts from IDLE at a negedge; cycle 0 is the first RUN cycle at (0,0).
  task automatic run_seq(input int ncyc, input int en_stop, input bit inject);
    int stop_at;
    stop_at = (en_stop / FT + 1) * FT;
    check_eq("idle_run_o", -1, 32'(run_o), 32'd0);
    check_eq("idle_ready", -1, 32'(pix_ready_o), 32'd0);
    en          = 1'b1;
    pix_valid_i = 1'b1;
    clr_err     = 1'b0;
    @(posedge pixclk_in);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge pixclk_in);
      if (c > 0) chk_out(c - 1, stop_at, inject);
      check_eq("run_o", c, 32'(run_o), 32'(c < stop_at));
      check_eq("pix_ready_o", c, 32'(pix_ready_o), 32'(ready_at(c, stop_at)));
      en          = (c < en_stop);
      pix_valid_i = valid_at(c, inject);
      clr_err     = clr_at(c, inject);
      pix_data_i  = dat(c);
      @(posedge pixclk_in);
    end
    @(negedge pixclk_in);
    chk_out(ncyc - 1, stop_at, inject);
    clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    check_eq({tag, "_de"}, -1, 32'(de_out), 32'd0);
    check_eq({tag, "_hs"}, -1, 32'(hs_out), 32'd0);
    check_eq({tag, "_vs"}, -1, 32'(vs_out), 32'd0);
    check_eq({tag, "_sof"}, -1, 32'(sof_o), 32'd0);
    check_eq({tag, "_data"}, -1, 32'(data_out), 32'd0);
    check_eq({tag, "_uf"}, -1, 32'(underflow_o), 32'd0);
    check_eq({tag, "_run"}, -1, 32'(run_o), 32'd0);
    check_eq({tag, "_ready"}, -1, 32'(pix_ready_o), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    clr_err     = 1'b0;
    pix_valid_i = 1'b0;
    pix_data_i  = '0;
    repeat (3) @(negedge pixclk_in);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge pixclk_in);
    chk_all_zero("post_reset_idle");

    // Three seamless frames with underflow/clear events, en dropped on line 2 of frame 3.
    run_seq(FT * 4 + 8, FT * 3 + 28, 1'b1);

    // Restart, then assert reset at h=5, v=2 of the new frame.
    run_seq(33, 100000, 1'b0);
    check_eq("pre_rst_ready", 33, 32'(pix_ready_o), 32'd1);
    check_eq("pre_rst_de", 33, 32'(de_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge pixclk_in);
      check_eq("rst_hold_ready", i, 32'(pix_ready_o), 32'd0);
      check_eq("rst_hold_run", i, 32'(run_o), 32'd0);
    end
    rst_n = 1'b1;
    run_seq(30, 100000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
